alu_display_ctrl: RTL and testbench
===================================

Name: alu_display_ctrl

Overview:
Controller that sequences the 4-digit seven-segment scan path. It captures an 8-bit ALU result and a 4-bit operation/letter code on a load strobe. It converts the result to BCD with a sequential shift-add-3 (double-dabble) engine, then presents stable ones/tens/hundreds/letter nibbles to the digit multiplexer. A free-running prescaled 2-bit scan select chooses which digit the multiplexer drives.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot; legal range 1..2^20; prescaler width = $clog2(REFRESH_DIV), minimum 1.
BLANK_LZ, 1, 1 = suppress leading zeros in hundreds/tens; 0 = always show all digits.
BLANK_CODE, 4'hF, nibble driven on a suppressed digit; the downstream decoder renders it dark.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
load  input  1  one-cycle strobe: capture result and code
result  input  8  unsigned ALU result, 0..255
code  input  4  letter/opcode nibble for the leftmost digit
scan_en  input  1  1 = scan advances; 0 = prescaler and scan_sel hold
scan_sel  output  2  digit select to the multiplexer (00 ones, 01 tens, 10 hundreds, 11 letter)
ones  output  4  BCD units digit, or BLANK_CODE
tens  output  4  BCD tens digit, or BLANK_CODE
hundreds  output  4  BCD hundreds digit, or BLANK_CODE
letter  output  4  captured code
busy  output  1  conversion in progress; load ignored while high
done  output  1  one-cycle pulse when the outputs update

Behaviour:
- Reset (async assert, any state): state=IDLE; prescaler=0; scan_sel=00; ones/tens/hundreds/letter=0; busy=0; done=0. Reset during CONVERT aborts the conversion and discards the captured data.
- Scan timing:
  - Prescaler counts 0..REFRESH_DIV-1 while scan_en=1.
  - On the edge where the count equals REFRESH_DIV-1, the prescaler returns to 0 and scan_sel increments, wrapping 11 -> 00.
  - REFRESH_DIV=1: scan_sel increments every enabled cycle.
  - scan_en=0 freezes both the prescaler and scan_sel.
  - Scanning is independent of the FSM and never stalls during conversion.
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE: load=1 at edge N captures result into shift register sr[7:0], code into code_r, clears bcd[11:0] and iter=0, goes to CONVERT. busy=1 from edge N.
  - CONVERT: each cycle, every bcd nibble >=5 gets +3, then {bcd,sr} shifts left by 1 and iter increments. After 8 iterations (edges N+1..N+8) the FSM goes to UPDATE.
  - UPDATE (edge N+9): outputs load atomically from bcd/code_r; done=1 for exactly one cycle; busy=0; FSM returns to IDLE.
  - Latency: load edge N -> new outputs visible after edge N+9. Next load is accepted at edge N+10.
- Outputs hold their previous values throughout CONVERT. There is no partial update and no display tearing.
- load while busy=1: ignored, with no queueing and no effect on the conversion in progress.
- load and rst together: rst wins.
- Leading-zero blanking, applied at UPDATE when BLANK_LZ=1:
  - hundreds = BLANK_CODE if its BCD value is 0.
  - tens = BLANK_CODE if the hundreds BCD is 0 and the tens BCD is 0.
  - ones is never blanked, so 0 displays as "0".
- Width rules: the maximum input 255 yields 2/5/5, so the hundreds BCD never exceeds 2. The bcd register is 12 bits with no overflow.

Test Plan:
- Reset mid-scan and mid-conversion: assert rst at cycle 3 of CONVERT -> all outputs 0, busy=0, scan_sel=00 immediately (async). No done pulse follows.
- Conversion, BLANK_LZ=0: load with result=8'd173, code=4'hA at edge N -> busy high edges N..N+9. Outputs hundreds=1, tens=7, ones=3, letter=A appear after N+9, with done pulsed one cycle. Result=255 -> 2/5/5.
- Blanking, BLANK_LZ=1: result=7 -> hundreds=F, tens=F, ones=7. Result=40 -> hundreds=F, tens=4, ones=0. Result=0 -> hundreds=F, tens=F, ones=0.
- Busy lockout: second load (result=99) at edge N+4 -> ignored, final display 173. Load at N+10 -> accepted, 0/9/9 (BLANK_LZ=0) appears after N+19.
- Scan sequencing, REFRESH_DIV=4: scan_sel steps 00,01,10,11,00 every 4 cycles. Drop scan_en for 6 cycles -> scan_sel and prescaler frozen, then resume from the same phase. REFRESH_DIV=1 -> scan_sel increments every cycle.
- Display stability: change result and code during CONVERT without load -> outputs unchanged until UPDATE. Outputs show the values captured at the load edge.

Source files
------------

// File: rtl/alu_display_if.sv
// Bus between the ALU result source and the seven-segment display controller.
interface alu_display_if;
  logic       load_i;
  logic [7:0] result_i;
  logic [3:0] code_i;
  logic       scan_en_i;
  logic [1:0] scan_sel_o;
  logic [3:0] ones_o;
  logic [3:0] tens_o;
  logic [3:0] hundreds_o;
  logic [3:0] letter_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output load_i, result_i, code_i, scan_en_i,
    input  scan_sel_o, ones_o, tens_o, hundreds_o, letter_o, busy_o, done_o
  );

  modport slave (
    input  load_i, result_i, code_i, scan_en_i,
    output scan_sel_o, ones_o, tens_o, hundreds_o, letter_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_display_ctrl.sv
// Captures an 8-bit result, converts it to BCD by double-dabble and drives
// stable digit nibbles plus a free-running prescaled scan select.
module alu_display_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  alu_display_if.slave bus
);

  localparam int unsigned   PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t        state_q;
  logic [PW-1:0] ps_q;
  logic [1:0]    sel_q;
  logic [7:0]    sr_q;
  logic [11:0]   bcd_q;
  logic [3:0]    iter_q;
  logic [3:0]    code_q;
  logic [3:0]    ones_q, tens_q, hund_q, letter_q;
  logic          busy_q, done_q;

  logic [11:0]   bcd_adj;
  logic [19:0]   shift_d;
  logic [3:0]    hund_d, tens_d;

  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    bcd_adj = dabble_adj(bcd_q);
    shift_d = {bcd_adj, sr_q} << 1;
    hund_d  = bcd_q[11:8];
    tens_d  = bcd_q[7:4];
    // Tens only blanks when hundreds is also zero, so 105 still shows "105".
    if (BLANK_LZ && bcd_q[11:8] == 4'd0) begin
      hund_d = BLANK_CODE;
      if (bcd_q[7:4] == 4'd0) tens_d = BLANK_CODE;
    end
  end

  // Scan path runs independently of the converter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q  <= '0;
      sel_q <= 2'b00;
    end else if (bus.scan_en_i) begin
      if (ps_q == PS_MAX) begin
        ps_q  <= '0;
        sel_q <= sel_q + 2'd1;
      end else begin
        ps_q  <= ps_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      code_q   <= '0;
      ones_q   <= '0;
      tens_q   <= '0;
      hund_q   <= '0;
      letter_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.load_i) begin
          sr_q    <= bus.result_i;
          code_q  <= bus.code_i;
          bcd_q   <= '0;
          iter_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= CONVERT;
        end
        CONVERT: begin
          bcd_q  <= shift_d[19:8];
          sr_q   <= shift_d[7:0];
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd7) state_q <= UPDATE;
        end
        UPDATE: begin
          ones_q   <= bcd_q[3:0];
          tens_q   <= tens_d;
          hund_q   <= hund_d;
          letter_q <= code_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.scan_sel_o = sel_q;
  assign bus.ones_o     = ones_q;
  assign bus.tens_o     = tens_q;
  assign bus.hundreds_o = hund_q;
  assign bus.letter_o   = letter_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_alu_display_ctrl.sv
// Directed bench: dut_a (REFRESH_DIV=4, no blanking), dut_b (REFRESH_DIV=1, blanking).
module tb_alu_display_ctrl;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_display_if ia();
  alu_display_if ib();

  alu_display_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0), .BLANK_CODE(4'hF))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  alu_display_ctrl #(.REFRESH_DIV(1), .BLANK_LZ(1'b1), .BLANK_CODE(4'hF))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load on one DUT, then check busy window, done pulse and final digits.
  task automatic conv(input bit use_b, input logic [7:0] res, input logic [3:0] cd,
                      input logic [3:0] eh, input logic [3:0] et, input logic [3:0] eo);
    if (use_b) begin ib.load_i = 1'b1; ib.result_i = res; ib.code_i = cd; end
    else       begin ia.load_i = 1'b1; ia.result_i = res; ia.code_i = cd; end
    tick();
    ia.load_i = 1'b0;
    ib.load_i = 1'b0;
    chk("conv_busy_start", use_b ? ib.busy_o : ia.busy_o, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("conv_no_done", use_b ? ib.done_o : ia.done_o, 0);
    end
    tick();
    chk("conv_hundreds", use_b ? ib.hundreds_o : ia.hundreds_o, eh);
    chk("conv_tens",     use_b ? ib.tens_o     : ia.tens_o,     et);
    chk("conv_ones",     use_b ? ib.ones_o     : ia.ones_o,     eo);
    chk("conv_letter",   use_b ? ib.letter_o   : ia.letter_o,   cd);
    chk("conv_done",     use_b ? ib.done_o     : ia.done_o,     1);
    chk("conv_busy_end", use_b ? ib.busy_o     : ia.busy_o,     0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    ia.load_i = 1'b0; ia.result_i = '0; ia.code_i = '0; ia.scan_en_i = 1'b0;
    ib.load_i = 1'b0; ib.result_i = '0; ib.code_i = '0; ib.scan_en_i = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst_sel_a",  ia.scan_sel_o, 0);
    chk("rst_ones_a", ia.ones_o, 0);
    chk("rst_hund_b", ib.hundreds_o, 0);
    chk("rst_busy_a", ia.busy_o, 0);
    chk("rst_done_b", ib.done_o, 0);
    rst = 1'b0;

    // REFRESH_DIV=1: one step per enabled cycle, then hold when disabled.
    ib.scan_en_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("scan_div1", ib.scan_sel_o, k);
    end
    ib.scan_en_i = 1'b0;
    tick();
    tick();
    chk("scan_div1_hold", ib.scan_sel_o, 3);

    // REFRESH_DIV=4: four cycles per slot, wrap 11->00.
    ia.scan_en_i = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      repeat (3) tick();
      chk("scan_div4_wait", ia.scan_sel_o, (s - 1) % 4);
      tick();
      chk("scan_div4_step", ia.scan_sel_o, s % 4);
    end
    tick();
    tick();
    ia.scan_en_i = 1'b0;
    repeat (6) tick();
    chk("scan_freeze", ia.scan_sel_o, 0);
    ia.scan_en_i = 1'b1;
    tick();
    chk("scan_resume_phase", ia.scan_sel_o, 0);
    tick();
    chk("scan_resume_step", ia.scan_sel_o, 1);
    ia.scan_en_i = 1'b0;

    // 173 with a load at N+4 (ignored) and inputs changing mid-conversion.
    ia.load_i = 1'b1; ia.result_i = 8'd173; ia.code_i = 4'hA;
    tick();
    ia.load_i = 1'b0;
    chk("lk_busy_n", ia.busy_o, 1);
    chk("lk_hold_n", ia.hundreds_o, 0);
    repeat (3) tick();
    ia.load_i = 1'b1; ia.result_i = 8'd99; ia.code_i = 4'h3;
    tick();
    ia.load_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lk_busy_mid", ia.busy_o, 1);
      chk("lk_ones_stable", ia.ones_o, 0);
    end
    tick();
    chk("lk_hund", ia.hundreds_o, 1);
    chk("lk_tens", ia.tens_o, 7);
    chk("lk_ones", ia.ones_o, 3);
    chk("lk_letter", ia.letter_o, 4'hA);
    chk("lk_done", ia.done_o, 1);
    chk("lk_busy_off", ia.busy_o, 0);
    ia.load_i = 1'b1; ia.result_i = 8'd99; ia.code_i = 4'h5;
    tick();
    ia.load_i = 1'b0;
    chk("n10_busy", ia.busy_o, 1);
    chk("n10_done_off", ia.done_o, 0);
    repeat (8) tick();
    chk("n18_ones_hold", ia.ones_o, 3);
    chk("n18_busy", ia.busy_o, 1);
    tick();
    chk("n19_hund", ia.hundreds_o, 0);
    chk("n19_tens", ia.tens_o, 9);
    chk("n19_ones", ia.ones_o, 9);
    chk("n19_letter", ia.letter_o, 5);
    chk("n19_done", ia.done_o, 1);

    conv(1'b0, 8'd255, 4'hC, 4'd2, 4'd5, 4'd5);

    // Leading-zero blanking.
    conv(1'b1, 8'd7,   4'h1, 4'hF, 4'hF, 4'd7);
    conv(1'b1, 8'd40,  4'h2, 4'hF, 4'd4, 4'd0);
    conv(1'b1, 8'd105, 4'h3, 4'd1, 4'd0, 4'd5);
    conv(1'b1, 8'd0,   4'h4, 4'hF, 4'hF, 4'd0);

    // Reset at cycle 3 of CONVERT, with load held alongside reset.
    ib.scan_en_i = 1'b1;
    ib.load_i = 1'b1; ib.result_i = 8'd200; ib.code_i = 4'hE;
    tick();
    ib.load_i = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    ib.load_i = 1'b1;
    #1;
    chk("arst_hund", ib.hundreds_o, 0);
    chk("arst_tens", ib.tens_o, 0);
    chk("arst_ones", ib.ones_o, 0);
    chk("arst_letter", ib.letter_o, 0);
    chk("arst_busy", ib.busy_o, 0);
    chk("arst_done", ib.done_o, 0);
    chk("arst_sel_b", ib.scan_sel_o, 0);
    chk("arst_sel_a", ia.scan_sel_o, 0);
    tick();
    chk("rst_beats_load", ib.busy_o, 0);
    rst = 1'b0;
    ib.load_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_no_done", ib.done_o, 0);
    end
    chk("post_rst_hund", ib.hundreds_o, 0);
    chk("post_rst_letter", ib.letter_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
